lsu_mem_stage: RTL and testbench

//  Parametrised load/store unit for the MEM stage of the RISC-V pipeline. Successor to the single-cycle

---
 rtl/lsu_mem_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: valid/ready request in, req/ack memory bus out, one response per request.
// Misaligned accesses are split into two lane-aligned beats; each beat may time out.
module lsu_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [4:0]          rsp_rd,
  output logic                rsp_wb,
  output logic                rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q;
  logic                is_load_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [OW-1:0]       off_q;
  logic                split_q;
  logic [ADDR_W-1:0]   addr1_q;
  logic [NB-1:0]       be1_q;
  logic [DATA_W-1:0]   wdata1_q;
  logic [DATA_W-1:0]   lo_q;
  logic [4:0]          rd_q;
  logic [CW-1:0]       cnt_q;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [NB-1:0]       mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [4:0]          rsp_rd_q;
  logic                rsp_wb_q;
  logic                rsp_err_q;

  logic [OW-1:0]       acc_off_s;
  logic [2*NB-1:0]     acc_mask_s;
  logic [2*NB-1:0]     acc_lanes_s;
  logic [2*DATA_W-1:0] acc_data_s;
  logic                acc_split_s;
  logic [ADDR_W-1:0]   acc_addr0_s;
  logic [OW+3:0]       hi_shift_s;
  logic [DATA_W-1:0]   lo_part_s;
  logic [DATA_W-1:0]   hi_part_s;
  logic [DATA_W-1:0]   load_data_s;
  logic                timeout_s;
  logic                unused_addr_s;

  // Keep the requested width, then sign- or zero-extend to the full register.
  function automatic logic [DATA_W-1:0] extend_f(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic uns);
    logic [DATA_W-1:0] keep;
    logic              sgn;
    case (sz)
      2'd0:    begin keep = DATA_W'(8'hFF);         sgn = d[7];  end
      2'd1:    begin keep = DATA_W'(16'hFFFF);      sgn = d[15]; end
      2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sgn = d[31]; end
      default: begin keep = {DATA_W{1'b1}};         sgn = 1'b0;  end
    endcase
    return (d & keep) | ((sgn && !uns) ? ~keep : {DATA_W{1'b0}});
  endfunction

  assign unused_addr_s = ^req_addr[DATA_W-1:ADDR_W];

  // Lane layout of an incoming request across one or two aligned beats.
  always_comb begin
    acc_off_s = req_addr[OW-1:0];
    case (req_size)
      2'b00:   acc_mask_s = (2*NB)'(4'h1);
      2'b01:   acc_mask_s = (2*NB)'(4'h3);
      2'b10:   acc_mask_s = (2*NB)'(4'hF);
      default: acc_mask_s = {(2*NB){1'b0}};
    endcase
    acc_lanes_s = acc_mask_s << acc_off_s;
    acc_data_s  = {{DATA_W{1'b0}}, req_wdata} << {acc_off_s, 3'b000};
    acc_split_s = |acc_lanes_s[2*NB-1:NB];
    acc_addr0_s = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  end

  // Realign returned data; the upper beat supplies the high bytes of a split load.
  always_comb begin
    lo_part_s  = mem_rdata >> {off_q, 3'b000};
    hi_shift_s = (OW+4)'(DATA_W) - {1'b0, off_q, 3'b000};
    hi_part_s  = mem_rdata << hi_shift_s;
    if (state_q == S_BEAT1) begin
      load_data_s = extend_f(lo_q | hi_part_s, size_q, uns_q);
    end else begin
      load_data_s = extend_f(lo_part_s, size_q, uns_q);
    end
  end

  assign timeout_s = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Request/beat/response sequencing with all bus and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= {OW{1'b0}};
      split_q     <= 1'b0;
      addr1_q     <= {ADDR_W{1'b0}};
      be1_q       <= {NB{1'b0}};
      wdata1_q    <= {DATA_W{1'b0}};
      lo_q        <= {DATA_W{1'b0}};
      rd_q        <= 5'd0;
      cnt_q       <= {CW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_be_q    <= {NB{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_rd_q    <= 5'd0;
      rsp_wb_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !halt) begin
            is_load_q <= (req_op == 2'b00);
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            off_q     <= acc_off_s;
            split_q   <= acc_split_s;
            addr1_q   <= acc_addr0_s + ADDR_W'(NB);
            be1_q     <= acc_lanes_s[2*NB-1:NB];
            wdata1_q  <= acc_data_s[2*DATA_W-1:DATA_W];
            rd_q      <= req_rd;
            cnt_q     <= {CW{1'b0}};
            if (req_op[1] || (req_size == 2'b11)) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= !req_op[1];
              rsp_wb_q    <= 1'b0;
              rsp_rdata_q <= {DATA_W{1'b0}};
              rsp_rd_q    <= req_rd;
            end else begin
              state_q     <= S_BEAT0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (req_op == 2'b01);
              mem_addr_q  <= acc_addr0_s;
              mem_be_q    <= acc_lanes_s[NB-1:0];
              mem_wdata_q <= acc_data_s[DATA_W-1:0];
            end
          end
        end
        S_BEAT0, S_BEAT1: begin
          // mem_req is low for one cycle between beats, so the second beat starts as a fresh request.
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            if ((state_q == S_BEAT0) && split_q) begin
              state_q     <= S_BEAT1;
              lo_q        <= lo_part_s;
              mem_addr_q  <= addr1_q;
              mem_be_q    <= be1_q;
              mem_wdata_q <= wdata1_q;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_wb_q    <= is_load_q;
              rsp_rdata_q <= is_load_q ? load_data_s : {DATA_W{1'b0}};
              rsp_rd_q    <= rd_q;
            end
          end else if (timeout_s) begin
            mem_req_q   <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_wb_q    <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_rd_q    <= rd_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          if (!halt) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_wb_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && !halt;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_wb    = rsp_wb_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: byte-level reference model feeds beat and response
// scoreboards; a memory responder with configurable wait states drives the bus.
module tb_lsu_mem_stage;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wb;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halt = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_wb;
  logic        rsp_err;

  int    checks = 0;
  int    errors = 0;
  int    wait_cfg = 0;
  bit    ack_en = 1'b1;
  int    wcnt = 0;
  int    beat_starts = 0;
  int    rsp_count = 0;
  bit    req_prev = 1'b0;
  bit    rv_prev = 1'b0;
  rsp_t  last_rsp = '0;

  beat_t       exp_beat_q[$];
  beat_t       obs_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] rdq[$];

  logic [93:0] outs;
  assign outs = {mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                 rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_err};

  lsu_mem_stage #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
    .rsp_wb(rsp_wb), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Memory responder: checks every cycle of a beat against the expected beat, acks after wait_cfg cycles.
  always @(negedge clk) begin
    beat_t       eb;
    logic [31:0] m;
    mem_ack = 1'b0;
    if (mem_req === 1'b1 && !req_prev) beat_starts++;
    req_prev = (mem_req === 1'b1);
    if (mem_req === 1'b1 && ack_en) begin
      checks++;
      if (exp_beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected addr=%h be=%b we=%b", mem_addr, mem_be, mem_we);
      end else begin
        eb = exp_beat_q[0];
        for (int i = 0; i < 4; i++) m[8*i +: 8] = (eb.be[i] && eb.we) ? 8'hFF : 8'h00;
        if ({mem_we, mem_addr, mem_be, mem_wdata & m} !== {eb.we, eb.addr, eb.be, eb.wdata & m}) begin
          errors++;
          $display("FAIL beat got we=%b addr=%h be=%b wdata=%h exp we=%b addr=%h be=%b wdata=%h",
                   mem_we, mem_addr, mem_be, mem_wdata & m, eb.we, eb.addr, eb.be, eb.wdata & m);
        end
      end
      if (wcnt >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = (rdq.size() != 0) ? rdq.pop_front() : 32'h0;
        wcnt      = 0;
        if (exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
        obs_q.push_back({mem_we, mem_addr, mem_be, mem_wdata});
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Response scoreboard: compares on the first cycle of rsp_valid and checks the held value afterwards.
  always @(negedge clk) begin
    rsp_t cur;
    rsp_t er;
    cur = {rsp_rdata, rsp_rd, rsp_wb, rsp_err};
    if (rsp_valid === 1'b1) begin
      checks++;
      if (!rv_prev) begin
        rsp_count++;
        if (exp_rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got rdata=%h rd=%0d wb=%b err=%b", rsp_rdata, rsp_rd, rsp_wb, rsp_err);
        end else begin
          er = exp_rsp_q.pop_front();
          if (cur !== er) begin
            errors++;
            $display("FAIL rsp got rdata=%h rd=%0d wb=%b err=%b exp rdata=%h rd=%0d wb=%b err=%b",
                     rsp_rdata, rsp_rd, rsp_wb, rsp_err, er.rdata, er.rd, er.wb, er.err);
          end
        end
        last_rsp = cur;
      end else if (cur !== last_rsp) begin
        errors++;
        $display("FAIL rsp_hold got %h exp %h", cur, last_rsp);
      end
    end else if (rst_n === 1'b1) begin
      checks++;
      if ({rsp_wb, rsp_err} !== 2'b00) begin
        errors++;
        $display("FAIL rsp_flags_idle got wb=%b err=%b exp 0 0", rsp_wb, rsp_err);
      end
    end
    rv_prev = (rsp_valid === 1'b1);
  end

  // Builds expectations byte by byte, then presents the request and returns just after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] r0, input logic [31:0] r1, input int waits, input bit to);
    beat_t       b0;
    beat_t       b1;
    rsp_t        er;
    logic [31:0] ld;
    logic [31:0] rsel;
    int          n;
    int          off;
    int          pos;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    er  = '{rdata: 32'h0, rd: rd, wb: 1'b0, err: 1'b0};
    if (op[1]) begin
      exp_rsp_q.push_back(er);
    end else if (size == 2'd3 || to) begin
      er.err = 1'b1;
      exp_rsp_q.push_back(er);
    end else begin
      b0 = '0;
      b1 = '0;
      b0.we   = (op == 2'b01);
      b1.we   = b0.we;
      b0.addr = {addr[15:2], 2'b00};
      b1.addr = b0.addr + 16'd4;
      ld = 32'h0;
      for (int i = 0; i < n; i++) begin
        pos = off + i;
        if (pos >= 4) begin
          rsel = r1;
          b1.be[pos-4] = 1'b1;
          b1.wdata[8*(pos-4) +: 8] = wdata[8*i +: 8];
        end else begin
          rsel = r0;
          b0.be[pos] = 1'b1;
          b0.wdata[8*pos +: 8] = wdata[8*i +: 8];
        end
        ld[8*i +: 8] = rsel[8*(pos%4) +: 8];
      end
      if (!uns && ld[8*n-1]) begin
        for (int i = n; i < 4; i++) ld[8*i +: 8] = 8'hFF;
      end
      exp_beat_q.push_back(b0);
      rdq.push_back(r0);
      if (off + n > 4) begin
        exp_beat_q.push_back(b1);
        rdq.push_back(r1);
      end
      if (op == 2'b00) begin
        er.rdata = ld;
        er.wb    = 1'b1;
      end
      exp_rsp_q.push_back(er);
    end
    @(negedge clk);
    req_op = op; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    for (int k = 0; k < 200 && req_ready !== 1'b1; k++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout req_ready=%b exp 1", req_ready);
    end
    wait_cfg = waits;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0 && rsp_valid !== 1'b1) break;
    end
    checks++;
    if (exp_rsp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp 0", exp_rsp_q.size());
      exp_rsp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 94'h0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word_load();
    obs_q.delete();
    issue(2'b00, 2'b10, 1'b0, 32'h10, 32'h0, 5'd1, 32'h8000_00FF, 32'h0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if ({mem_req, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL word_load_e1 got req=%b rsp_valid=%b exp 1 0", mem_req, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL word_load_e2 got rsp_valid=%b exp 1", rsp_valid); end
    drain();
    checks++;
    if (last_rsp.rdata !== 32'h8000_00FF || last_rsp.wb !== 1'b1) begin
      errors++; $display("FAIL word_load_data got %h wb=%b exp 800000ff wb=1", last_rsp.rdata, last_rsp.wb);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 16'h0010 || obs_q[0].be !== 4'b1111) begin
      errors++; $display("FAIL word_load_beat got n=%0d exp one beat addr 0010 be 1111", obs_q.size());
    end
  endtask

  task automatic test_byte_load();
    obs_q.delete();
    issue(2'b00, 2'b00, 1'b0, 32'h13, 32'h0, 5'd2, 32'h8012_3456, 32'h0, 0, 1'b0);
    drain();
    checks++;
    if (last_rsp.rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL byte_signed got %h exp ffffff80", last_rsp.rdata);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].be !== 4'b1000) begin
      errors++; $display("FAIL byte_be got n=%0d exp be 1000", obs_q.size());
    end
    issue(2'b00, 2'b00, 1'b1, 32'h13, 32'h0, 5'd2, 32'h80AB_CDEF, 32'h0, 0, 1'b0);
    drain();
    checks++;
    if (last_rsp.rdata !== 32'h0000_0080) begin
      errors++; $display("FAIL byte_unsigned got %h exp 00000080", last_rsp.rdata);
    end
  endtask

  task automatic test_split_store();
    int c;
    c = rsp_count;
    obs_q.delete();
    issue(2'b01, 2'b10, 1'b0, 32'h6, 32'hAABB_CCDD, 5'd3, 32'h0, 32'h0, 0, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL split_store_beats got %0d exp 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {1'b1, 16'h0004, 4'b1100, 32'hCCDD_0000}) begin
        errors++; $display("FAIL split_store_b0 got %h exp 1_0004_c_ccdd0000", obs_q[0]);
      end
      checks++;
      if (obs_q[1] !== {1'b1, 16'h0008, 4'b0011, 32'h0000_AABB}) begin
        errors++; $display("FAIL split_store_b1 got %h exp 1_0008_3_0000aabb", obs_q[1]);
      end
    end
    checks++;
    if (rsp_count - c != 1 || last_rsp.wb !== 1'b0) begin
      errors++; $display("FAIL split_store_rsp got count=%0d wb=%b exp 1 0", rsp_count - c, last_rsp.wb);
    end
  endtask

  task automatic test_split_waits();
    issue(2'b00, 2'b01, 1'b1, 32'h3, 32'h0, 5'd4, 32'h11A5_A5A5, 32'hA5A5_A522, 3, 1'b0);
    drain();
    checks++;
    if (last_rsp.rdata !== 32'h0000_2211) begin
      errors++; $display("FAIL split_wait_data got %h exp 00002211", last_rsp.rdata);
    end
    obs_q.delete();
    issue(2'b00, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 5'd5, $urandom, $urandom, 1, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[0].addr !== 16'hFFFC || obs_q[0].be !== 4'b1000 ||
        obs_q[1].addr !== 16'h0000 || obs_q[1].be !== 4'b0001) begin
      errors++; $display("FAIL wrap_beats got n=%0d exp fffc/1000 then 0000/0001", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 65535)), $urandom, 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom_range(0, 2), 1'b0);
    end
    drain();
  endtask

  task automatic test_timeout();
    int b;
    int hi;
    ack_en = 1'b0;
    b  = beat_starts;
    hi = 0;
    issue(2'b00, 2'b10, 1'b0, 32'h42, 32'h0, 5'd7, 32'h0, 32'h0, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1) hi++;
      else if (hi > 0) break;
    end
    checks++;
    if (hi != 8) begin errors++; $display("FAIL timeout_cycles got %0d exp 8", hi); end
    drain();
    checks++;
    if (beat_starts - b != 1) begin errors++; $display("FAIL timeout_beats got %0d exp 1", beat_starts - b); end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_midbeat();
    int b;
    b = beat_starts;
    issue(2'b00, 2'b10, 1'b0, 32'h22, 32'h0, 5'd8, $urandom, $urandom, 5, 1'b0);
    for (int k = 0; k < 40 && beat_starts != b + 2; k++) @(negedge clk);
    checks++;
    if (beat_starts != b + 2) begin errors++; $display("FAIL midbeat_reach got %0d exp 2", beat_starts - b); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 94'h0) begin errors++; $display("FAIL midbeat_reset_outs got %h exp 0", outs); end
    exp_beat_q.delete();
    rdq.delete();
    exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || outs !== 94'h0) begin
      errors++; $display("FAIL midbeat_release got ready=%b outs=%h exp 1 0", req_ready, outs);
    end
  endtask

  task automatic test_halt_resp();
    int c;
    c = rsp_count;
    issue(2'b00, 2'b10, 1'b0, 32'h20, 32'h0, 5'd9, $urandom, 32'h0, 0, 1'b0);
    halt = 1'b1;
    req_op = 2'b01; req_size = 2'b10; req_addr = 32'h30; req_rd = 5'd10;
    req_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, mem_req} !== 3'b100) begin
        errors++; $display("FAIL halt_hold got valid=%b ready=%b req=%b exp 1 0 0", rsp_valid, req_ready, mem_req);
      end
    end
    halt = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL halt_release got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    drain();
    checks++;
    if (rsp_count - c != 1) begin errors++; $display("FAIL halt_count got %0d exp 1", rsp_count - c); end
  endtask

  initial begin
    #1;
    test_reset();
    test_word_load();
    test_byte_load();
    test_split_store();
    test_split_waits();
    test_back_to_back();
    test_timeout();
    test_halt_resp();
    test_reset_midbeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
